// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the execute/writeback pipeline.
// An execute word is held for one cycle and written to the register file,
// or held across a memory write handshake. Completed instructions are counted.
// The optional forwarding port is enabled by defining the macro WB_FWD_EN.
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] i_reg1,
  input  logic [31:0] i_reg2,
  input  logic        i_vld,
  output logic        o_stall,
  output logic        o_rf_we,
  output logic [2:0]  o_rf_idx,
  output logic [31:0] o_rf_data,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_data,
  input  logic        i_mem_ack,
  output logic [15:0] o_retired
`ifdef WB_FWD_EN
  ,
  output logic        o_fwd_vld,
  output logic [2:0]  o_fwd_idx,
  output logic [31:0] o_fwd_data
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RFWR   = 2'd1;
  localparam logic [1:0] MEMREQ = 2'd2;

  localparam logic [1:0] OP_JMP = 2'b11;

  logic [1:0]  state;
  logic [1:0]  hold_op;
  logic [2:0]  hold_sr1;
  logic [31:0] hold_result;

  logic [1:0]  in_op;
  logic        in_memwb;
  logic [2:0]  in_sr1;
  logic        capture;
  logic        to_mem;
  logic        ack_seen;
  logic        retire;
  logic        unused_ctrl_bits;

  assign in_op    = i_reg2[1:0];
  assign in_memwb = i_reg2[2];
  assign in_sr1   = i_reg2[5:3];

  // Upper control bits carry nothing for this stage.
  assign unused_ctrl_bits = ^i_reg2[31:6];

  // A word is accepted whenever the stage is not waiting on memory.
  assign capture  = i_vld && (state != MEMREQ);
  assign to_mem   = in_memwb && (in_op != OP_JMP);
  assign ack_seen = (state == MEMREQ) && i_mem_ack;
  assign retire   = (state == RFWR) || ack_seen;

  assign o_stall   = (state == MEMREQ);
  assign o_mem_req = (state == MEMREQ);
  assign o_rf_we   = (state == RFWR) && (hold_op != OP_JMP);
  assign o_rf_idx  = hold_sr1;
  assign o_rf_data = hold_result;

  // State sequencing; RFWR chains straight into the next word when one is offered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (state == MEMREQ) begin
      if (i_mem_ack) begin
        state <= IDLE;
      end
    end else if (capture) begin
      state <= to_mem ? MEMREQ : RFWR;
    end else begin
      state <= IDLE;
    end
  end

  // Holding register for the word being written back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_op     <= 2'd0;
      hold_sr1    <= 3'd0;
      hold_result <= 32'd0;
    end else if (capture) begin
      hold_op     <= in_op;
      hold_sr1    <= in_sr1;
      hold_result <= i_reg1[63:32];
    end
  end

  // Memory address/data only change when a new memory write is accepted, so they
  // keep their last value while no request is outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_mem_addr <= 32'd0;
      o_mem_data <= 32'd0;
    end else if (capture && to_mem) begin
      o_mem_addr <= i_reg1[31:0];
      o_mem_data <= i_reg1[63:32];
    end
  end

  // Retired-instruction counter, free-running wrap at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_retired <= 16'd0;
    end else if (retire) begin
      o_retired <= o_retired + 16'd1;
    end
  end

`ifdef WB_FWD_EN
  assign o_fwd_vld  = o_rf_we;
  assign o_fwd_idx  = o_fwd_vld ? hold_sr1 : 3'd0;
  assign o_fwd_data = o_fwd_vld ? hold_result : 32'd0;
`endif

endmodule
